// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared rv32 definitions: NOP encoding, prefetch states
package rv32_pkg;

    localparam logic [31:0] RV32_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        PF_FETCH   = 2'd0,
        PF_DISCARD = 2'd1,
        PF_HALTED  = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } pf_entry_t;

endpackage

// File: rtl/rv32_prefetch_fifo.sv
// rtl/rv32_prefetch_fifo.sv - synchronous flushable FIFO of {pc, instr, fault}
module rv32_prefetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [31:0]                wr_pc,
    input  logic [31:0]                wr_instr,
    input  logic                       wr_fault,
    input  logic                       rd_en,
    output logic                       valid,
    output logic [31:0]                rd_pc,
    output logic [31:0]                rd_instr,
    output logic                       rd_fault,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    pf_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_wr;
    logic            do_rd;

    assign do_wr = wr_en && (count != FULL);
    assign do_rd = rd_en && (count != '0);

    // Pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: only slots behind a valid pointer are read
    always_ff @(posedge clk) begin
        if (!flush && do_wr) begin
            mem[wr_ptr] <= '{pc: wr_pc, instr: wr_instr, fault: wr_fault};
        end
    end

    assign valid    = (count != '0);
    assign rd_pc    = valid ? mem[rd_ptr].pc    : 32'h0;
    assign rd_instr = valid ? mem[rd_ptr].instr : RV32_NOP;
    assign rd_fault = valid ? mem[rd_ptr].fault : 1'b0;

endmodule

// File: rtl/rv32_instr_prefetch.sv
// rtl/rv32_instr_prefetch.sv - single-outstanding instruction prefetcher with redirect
module rv32_instr_prefetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        consume_in,
    output logic        bus_req_out,
    output logic [31:0] bus_addr_out,
    input  logic        bus_gnt_in,
    input  logic        bus_rvalid_in,
    input  logic [31:0] bus_rdata_in,
    input  logic        bus_err_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        fault_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    pf_state_e      state;
    pf_state_e      state_next;
    logic [31:0]    fetch_addr;
    logic [31:0]    req_pc;
    logic           outstanding;
    logic           resp;
    logic           enq;
    logic           req_raw;
    logic [CW-1:0]  count;
    logic [CW:0]    occupancy;
    logic           unused_pc_bits;

    assign resp           = bus_rvalid_in && outstanding;
    assign occupancy      = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign unused_pc_bits = ^redirect_pc_in[1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= PF_FETCH;
        else        state <= state_next;
    end

    // Next state: a redirect with a response still in flight must drop that response
    always_comb begin
        state_next = state;
        unique case (state)
            PF_FETCH: begin
                if (redirect_in)            state_next = (outstanding && !bus_rvalid_in) ? PF_DISCARD : PF_FETCH;
                else if (resp && bus_err_in) state_next = PF_HALTED;
            end
            PF_DISCARD: begin
                if (bus_rvalid_in) state_next = PF_FETCH;
            end
            PF_HALTED: begin
                if (redirect_in) state_next = (outstanding && !bus_rvalid_in) ? PF_DISCARD : PF_FETCH;
            end
            default: state_next = PF_FETCH;
        endcase
    end

    // Outputs: requests only while fetching, never in a redirect cycle or after a fault response
    always_comb begin
        req_raw = 1'b0;
        enq     = 1'b0;
        if (state == PF_FETCH) begin
            enq     = resp && !redirect_in;
            req_raw = !redirect_in
                   && (!outstanding || (resp && !bus_err_in))
                   && (occupancy < DEPTH_L);
        end
    end

    assign bus_req_out  = req_raw && reset;
    assign bus_addr_out = fetch_addr;

    // Fetch address, address of the in-flight request, and outstanding flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_addr  <= RESET_VECTOR;
            req_pc      <= 32'h0;
            outstanding <= 1'b0;
        end else begin
            if (redirect_in) begin
                fetch_addr <= {redirect_pc_in[31:2], 2'b00};
            end else if (bus_req_out && bus_gnt_in) begin
                fetch_addr <= fetch_addr + 32'd4;
                req_pc     <= fetch_addr;
            end
            if (bus_req_out && bus_gnt_in) outstanding <= 1'b1;
            else if (bus_rvalid_in)        outstanding <= 1'b0;
        end
    end

    rv32_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_in),
        .wr_en    (enq),
        .wr_pc    (req_pc),
        .wr_instr (bus_err_in ? RV32_NOP : bus_rdata_in),
        .wr_fault (bus_err_in),
        .rd_en    (consume_in && !redirect_in),
        .valid    (valid_out),
        .rd_pc    (pc_out),
        .rd_instr (instr_out),
        .rd_fault (fault_out),
        .count    (count)
    );

endmodule

// File: tb/tb_rv32_instr_prefetch.sv
// tb/tb_rv32_instr_prefetch.sv - randomized bench with queue-based reference model
module tb_rv32_instr_prefetch;

    localparam logic [31:0] RV    = 32'h00000100;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        consume_in = 1'b0;
    logic        bus_req_out;
    logic [31:0] bus_addr_out;
    logic        bus_gnt_in = 1'b0;
    logic        bus_rvalid_in = 1'b0;
    logic [31:0] bus_rdata_in = '0;
    logic        bus_err_in = 1'b0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        fault_out;

    rv32_instr_prefetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .consume_in(consume_in),
        .bus_req_out(bus_req_out), .bus_addr_out(bus_addr_out),
        .bus_gnt_in(bus_gnt_in), .bus_rvalid_in(bus_rvalid_in),
        .bus_rdata_in(bus_rdata_in), .bus_err_in(bus_err_in),
        .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out), .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    int          mode;          // 0 fetching, 1 dropping a stale response, 2 halted by fault
    bit          m_out;
    logic [31:0] m_pc;
    logic [31:0] m_rpc;
    bit          b_pend;
    logic [31:0] b_addr;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode   = 0;
        m_out  = 0;
        m_pc   = RV;
        m_rpc  = '0;
        b_pend = 0;
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit cons,
                         input bit gnt, input bit rv_en, input bit err_en);
        bit   exp_req;
        bit   rv;
        bit   dut_hs;
        logic [31:0] hs_addr;
        ent_t e;
        @(negedge clk);
        redirect_in    = redir;
        redirect_pc_in = rpc;
        consume_in     = cons;
        bus_gnt_in     = gnt;
        rv             = rv_en && b_pend;
        bus_rvalid_in  = rv;
        bus_rdata_in   = b_addr ^ 32'h5A5A0F0F;
        bus_err_in     = err_en;
        #1;
        exp_req = (mode == 0) && !redir && (!m_out || (rv && !err_en)) && (q.size() + int'(m_out) < DEPTH);
        check("valid", 32'(valid_out), 32'(q.size() > 0));
        check("pc",    pc_out,    q.size() > 0 ? q[0].pc : 32'h0);
        check("instr", instr_out, q.size() > 0 ? q[0].instr : NOP);
        check("fault", 32'(fault_out), q.size() > 0 ? 32'(q[0].fault) : 32'h0);
        check("req",   32'(bus_req_out), 32'(exp_req));
        if (exp_req) check("addr", bus_addr_out, m_pc);
        dut_hs  = bus_req_out && gnt;
        hs_addr = bus_addr_out;
        @(posedge clk);
        if (redir) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_out && !rv) mode = 1;
            else begin mode = 0; m_out = 0; end
        end else begin
            if (cons && q.size() > 0) void'(q.pop_front());
            if (rv) begin
                m_out = 0;
                if (mode == 0) begin
                    e.pc = m_rpc; e.instr = err_en ? NOP : bus_rdata_in; e.fault = err_en;
                    q.push_back(e);
                    if (err_en) mode = 2;
                end else if (mode == 1) mode = 0;
            end
            if (exp_req && gnt) begin
                m_out = 1;
                m_rpc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
        if (rv) b_pend = 0;
        if (dut_hs) begin b_pend = 1; b_addr = hs_addr; end
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_pc",    pc_out, 32'h0);
        check("rst_instr", instr_out, NOP);
        check("rst_fault", 32'(fault_out), 32'h0);
        check("rst_req",   32'(bus_req_out), 32'h0);
        @(posedge clk); #2 reset = 1'b1;

        // Streaming from the reset vector, buffer fills to DEPTH, then one consume
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 0);
        // Drain, leave a request outstanding, redirect to a misaligned target
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 0, 0);
        cycle(1, 32'h2002, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0);
        // Wrap-around at the top of the address space
        cycle(1, 32'hFFFFFFFE, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 1, 0);
        // Access fault at 0x40, halt, then redirect to 0x80
        cycle(1, 32'h40, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 0);
        cycle(1, 32'h80, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
        // Redirect plus consume in the cycle the response arrives
        cycle(1, 32'h300, 1, 1, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] t;
            bit r;
            r = ($urandom_range(15) == 0) || (mode == 2 && $urandom_range(3) == 0);
            t = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15)))
                                         : 32'($urandom_range(32'hFFFF));
            cycle(r, t, ($urandom_range(7) < ((i / 200) % 2 == 0 ? 2 : 6)),
                  ($urandom_range(2) != 0), $urandom_range(1) == 1, $urandom_range(19) == 0);
            if (i == 700) begin
                @(negedge clk);
                #3 reset = 1'b0;
                #1;
                check("mid_rst_valid", 32'(valid_out), 32'h0);
                check("mid_rst_req",   32'(bus_req_out), 32'h0);
                check("mid_rst_instr", instr_out, NOP);
                model_reset();
                redirect_in = 0; consume_in = 0; bus_gnt_in = 0; bus_rvalid_in = 0; bus_err_in = 0;
                @(posedge clk); #2 reset = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32_instr_prefetch.md
RV32_INSTR_PREFETCH -- requirements
Module: rv32_instr_prefetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_VECTOR, default 32'b0: first fetch address after reset.
REQ-003 Parameter DEPTH, default 4: buffer entries; power of two, at least 2.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port redirect_in, input, 1: fetch-stage PC overwrite (trap, mispredict or predicted-taken).
REQ-007 Port redirect_pc_in, input, 32: new fetch address, valid with redirect_in.
REQ-008 Port consume_in, input, 1: fetch stage takes the head entry this cycle.
REQ-009 Port bus_req_out, output, 1: read request.
REQ-010 Port bus_addr_out, output, 32: read address, word aligned.
REQ-011 Port bus_gnt_in, input, 1: request accepted this cycle.
REQ-012 Port bus_rvalid_in, input, 1: response valid.
REQ-013 Port bus_rdata_in, input, 32: response instruction word.
REQ-014 Port bus_err_in, input, 1: response is an access fault, qualified by bus_rvalid_in.
REQ-015 Port valid_out, output, 1: head entry present.
REQ-016 Port pc_out, output, 32: head entry address.
REQ-017 Port instr_out, output, 32: head entry word.
REQ-018 Port fault_out, output, 1: head entry is an instruction access fault.

Function
REQ-019 Fetch address counter fetch_addr SHALL advance by 4 on each granted request, with 32-bit wrap-around (0xFFFFFFFC -> 0x00000000).
REQ-020 Redirect SHALL load fetch_addr with {redirect_pc_in[31:2], 2'b00}.
REQ-021 At most one request SHALL be outstanding; bus_req_out stays high with a stable address until bus_gnt_in.
REQ-022 A request SHALL be raised only when entry count plus outstanding count is below DEPTH, so the buffer never overflows.
REQ-023 States SHALL be FETCH (issue requests), DISCARD (drop one stale response) and HALTED (stop issuing after a fault).
REQ-024 FETCH -> DISCARD: redirect while a request is outstanding and its response is not arriving in the same cycle.
REQ-025 DISCARD -> FETCH: on bus_rvalid_in; the response is dropped and is not enqueued.
REQ-026 FETCH -> HALTED: on bus_rvalid_in with bus_err_in; enqueue {pc, 32'h00000013, fault=1}.
REQ-027 HALTED or DISCARD: redirect SHALL reload fetch_addr; HALTED -> FETCH, or -> DISCARD if a response is still outstanding.
REQ-028 Redirect SHALL empty the buffer in the same cycle; a response arriving in the redirect cycle SHALL be discarded; no request issues in the redirect cycle.
REQ-029 Redirect SHALL take priority over a simultaneous consume_in.
REQ-030 A response SHALL be enqueued at the tail; an entry is visible on the outputs the cycle after bus_rvalid_in, with no bypass.
REQ-031 Minimum latency SHALL be: grant in cycle N, rvalid in N+1, valid_out in N+2.
REQ-032 consume_in with valid_out low SHALL be ignored.
REQ-033 Simultaneous enqueue and consume SHALL keep the count unchanged.
REQ-034 With valid_out low, pc_out, instr_out and fault_out SHALL read 0, 32'h00000013 and 0 respectively.

Reset
REQ-035 Reset assertion SHALL asynchronously set valid_out=0, fault_out=0, pc_out=0, instr_out=32'h00000013, bus_req_out=0, buffer empty, state FETCH and fetch_addr=RESET_VECTOR.
REQ-036 The first request SHALL be raised in the first cycle after reset deassertion.
REQ-037 Reset mid-transaction SHALL abandon any outstanding response; the bus is required to drop it as well.

Structure
REQ-038 The state enum and the NOP constant SHALL live in the shared rv32 opcode/definitions package.
REQ-039 The buffer SHALL be one sub-module, rv32_prefetch_fifo: synchronous FIFO with flush, DEPTH entries of {pc, instr, fault}.

Verification
REQ-040 Reset with RESET_VECTOR=0x100, then grant and rvalid every cycle -> addresses 0x100, 0x104, 0x108; first valid_out two cycles after the first grant.
REQ-041 DEPTH=4, consume_in held low -> exactly 4 entries; bus_req_out low thereafter; one consume -> a request re-raised the next cycle.
REQ-042 Redirect to 0x2002 while a response is outstanding -> response dropped; next request to 0x2000; buffer empty in the redirect cycle.
REQ-043 bus_err_in on address 0x40 -> entry {0x40, 0x00000013, fault=1}; no further requests until redirect to 0x80 -> request to 0x80.
REQ-044 fetch_addr 0xFFFFFFFC granted -> next request to 0x00000000.
REQ-045 Redirect and consume_in in the same cycle as rvalid -> valid_out=0 next cycle; no entry from that response.
